// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard transmitter: frame size,
// sequencer states and the odd-parity helper.
package ps2_pkg;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;

  // Sequencer states: idle lines, clock-high half, clock-low half, inter-frame gap.
  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    GAP
  } ps2_state_t;

  // Odd parity bit: makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small byte FIFO feeding the PS/2 transmitter. Read data is presented
// combinationally from the head entry so the sequencer can pop and load its
// shift register on the same edge. Flags are registered.
module ps2_tx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is silently ignored.
  assign do_push  = push & ~full_reg;
  assign do_pop   = pop & ~empty_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;

  // Storage array; no reset needed since contents are only read when valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Occupancy bookkeeping for the next cycle.
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
      2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers, count and registered flags; pointers wrap as DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
      empty_reg <= (count_next == '0);
    end
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard emulator: buffers scan-code bytes and serialises
// each as an 11-bit frame, generating both the PS/2 clock and data lines.
// Data only changes while the PS/2 clock is high so the host can sample
// during the low phase.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 2500,
  parameter int GAP_BITS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  // The gap is the longest interval timed, so it sizes the shared counter.
  localparam int GAP_CLKS = GAP_BITS * 2 * CLK_DIV;
  localparam int CNT_W    = $clog2(GAP_CLKS);
  localparam int IDX_W    = $clog2(PS2_FRAME_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CLKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PS2_FRAME_BITS - 1);

  ps2_state_t                state_reg;
  ps2_state_t                state_next;
  logic [CNT_W-1:0]          cnt_reg;
  logic [CNT_W-1:0]          cnt_next;
  logic [IDX_W-1:0]          idx_reg;
  logic [IDX_W-1:0]          idx_next;
  logic [PS2_FRAME_BITS-1:0] shift_reg;
  logic [PS2_FRAME_BITS-1:0] shift_next;
  logic                      ps2_clk_reg;
  logic                      ps2_clk_next;
  logic                      ps2_data_reg;
  logic                      ps2_data_next;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [7:0]                fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [PS2_FRAME_BITS-1:0] frame_word;

  // Ready comes straight from the registered full flag, so a pop on the same
  // edge never lets a push into a full FIFO.
  assign tx_ready  = ~fifo_full;
  assign fifo_push = tx_valid & tx_ready;
  assign ps2_clk   = ps2_clk_reg;
  assign ps2_data  = ps2_data_reg;
  assign busy      = (state_reg != IDLE) | ~fifo_empty;

  // Line order from bit 0: start, data LSB first, odd parity, stop.
  assign frame_word = {1'b1, odd_parity(fifo_data), fifo_data, 1'b0};

  ps2_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer state, counters, shift register and output line registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      shift_reg    <= '1;
      ps2_clk_reg  <= 1'b1;
      ps2_data_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      ps2_clk_reg  <= ps2_clk_next;
      ps2_data_reg <= ps2_data_next;
    end
  end

  // Next-state logic: half-period timing, bit stepping and the trailing gap.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    ps2_clk_next  = ps2_clk_reg;
    ps2_data_next = ps2_data_reg;
    fifo_pop      = 1'b0;

    case (state_reg)
      IDLE: begin
        ps2_clk_next  = 1'b1;
        ps2_data_next = 1'b1;
        if (!fifo_empty) begin
          // Pop and put the start bit on the line with the clock still high.
          fifo_pop      = 1'b1;
          shift_next    = frame_word;
          ps2_data_next = frame_word[0];
          idx_next      = '0;
          cnt_next      = '0;
          state_next    = HIGH;
        end
      end

      HIGH: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          ps2_clk_next = 1'b0;
          state_next   = LOW;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      LOW: begin
        if (cnt_reg == HALF_LAST) begin
          // Clock rises here; data may change on this same edge.
          cnt_next     = '0;
          ps2_clk_next = 1'b1;
          if (idx_reg == LAST_IDX) begin
            ps2_data_next = 1'b1;
            state_next    = GAP;
          end else begin
            idx_next      = idx_reg + IDX_W'(1);
            shift_next    = {1'b1, shift_reg[PS2_FRAME_BITS-1:1]};
            ps2_data_next = shift_reg[1];
            state_next    = HIGH;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: a line-level receiver model decodes frames at
// the PS/2 clock falls and checks contents, edge timing, start latency,
// busy and tx_ready against a byte-queue model of the transmitter.
module tb_ps2_keyboard_tx;

  localparam int CD     = 4;
  localparam int GB     = 2;
  localparam int FD     = 4;
  localparam int PERIOD = (22 + 2 * GB) * CD + 1;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          acc_q[$];
  logic [7:0]  dat_q[$];
  logic [10:0] done_q[$];
  int          start_q[$];
  int          n_started = 0;
  int          last_start = -100000;
  bit          in_frame = 1'b0;
  int          fs = 0;
  int          nbits = 0;
  int          cur = 0;
  logic [10:0] bits = '1;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ps2_keyboard_tx #(
    .CLK_DIV    (CD),
    .GAP_BITS   (GB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame as it should appear on the line, bit k at index k.
  function automatic logic [10:0] expect_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Bytes accepted by the current edge that have not yet started.
  function automatic int fifo_level();
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] <= cyc) n++;
    return n - n_started;
  endfunction

  // Receiver model and continuous checks, sampled mid-cycle.
  always @(negedge clk) begin
    int exp_s;
    int lvl;
    if (!resetn) begin
      check_val("rst_clk", ps2_clk, 1);
      check_val("rst_data", ps2_data, 1);
      check_val("rst_ready", tx_ready, 1);
      check_val("rst_busy", busy, 0);
      in_frame   = 1'b0;
      n_started  = 0;
      last_start = -100000;
      acc_q.delete();
      dat_q.delete();
    end else begin
      if (!in_frame) begin
        if (!ps2_data) begin
          check_val("start_clk_high", ps2_clk, 1);
          if (n_started < acc_q.size()) begin
            exp_s = acc_q[n_started] + 1;
            if (last_start + PERIOD > exp_s) exp_s = last_start + PERIOD;
            check_val("start_time", cyc, exp_s);
          end else begin
            check_val("unexpected_start", n_started, acc_q.size());
          end
          in_frame   = 1'b1;
          fs         = cyc;
          nbits      = 0;
          bits       = '1;
          cur        = n_started;
          n_started++;
          last_start = cyc;
          start_q.push_back(cyc);
        end else begin
          check_val("idle_clk", ps2_clk, 1);
        end
      end else begin
        if (prev_clk && !ps2_clk) begin
          check_val("fall_time", cyc, fs + (2 * nbits + 1) * CD);
          if (nbits < 11) bits[nbits] = ps2_data;
          nbits++;
        end else if (!prev_clk && ps2_clk) begin
          check_val("rise_time", cyc, fs + 2 * nbits * CD);
          if (nbits >= 11) begin
            if (cur < dat_q.size()) check_val("frame", bits, expect_frame(dat_q[cur]));
            else check_val("frame_no_byte", cur, dat_q.size());
            $display("frame: bits=%011b byte=%02h start=%0d", bits, bits[8:1], fs);
            done_q.push_back(bits);
            in_frame = 1'b0;
          end
        end else if (!prev_clk && !ps2_clk) begin
          check_val("data_stable_low", ps2_data, prev_data);
        end
      end
      lvl = fifo_level();
      check_val("tx_ready", tx_ready, lvl < FD);
      check_val("busy", busy, (lvl > 0) || (cyc < last_start + PERIOD - 1));
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  // One cycle of stimulus, applied just after the falling edge.
  task automatic drive(input bit v, input logic [7:0] d);
    @(negedge clk);
    #1;
    tx_valid = v;
    tx_data  = d;
    if (v && (fifo_level() < FD)) begin
      acc_q.push_back(cyc + 1);
      dat_q.push_back(d);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((n_started < acc_q.size() || in_frame || cyc < last_start + PERIOD) && k < budget) begin
      drive(1'b0, 8'($urandom));
      k++;
    end
    check_val("drain_in_budget", k < budget, 1);
  endtask

  initial begin
    int base;
    int a0;
    int i0;
    int k;
    logic [10:0] fr;
    logic [7:0] bytes5 [5];
    int exp_par [4];

    // Reset and quiet period.
    repeat (5) drive(1'b0, 8'($urandom));
    resetn = 1'b1;
    repeat (100) drive(1'b0, 8'($urandom));
    check_val("quiet_starts", start_q.size(), 0);

    // Single byte 0x1C.
    base = done_q.size();
    drive(1'b1, 8'h1C);
    drive(1'b0, 8'h00);
    drain(400);
    check_val("1c_count", done_q.size(), base + 1);
    fr = done_q[base];
    check_val("1c_bits", fr, 11'b10000111000);
    check_val("1c_latency", last_start - acc_q[$], 1);

    // Parity cases.
    base = done_q.size();
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h01);
    drive(1'b0, 8'h00);
    drain(1500);
    check_val("par_count", done_q.size(), base + 4);
    exp_par = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      fr = done_q[base + i];
      check_val("parity_bit", fr[9], exp_par[i]);
    end

    // Back-to-back F0 1C.
    i0 = start_q.size();
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h1C);
    k = 0;
    while (start_q.size() < i0 + 2 && k < 400) begin drive(1'b0, 8'h00); k++; end
    check_val("b2b_starts", start_q.size(), i0 + 2);
    check_val("b2b_spacing", start_q[i0 + 1] - start_q[i0], PERIOD);
    k = 0;
    while (busy && k < 300) begin drive(1'b0, 8'h00); k++; end
    check_val("busy_fall", cyc - start_q[i0 + 1], PERIOD - 1);
    drain(400);

    // FIFO full: six pushes, five accepted.
    base = done_q.size();
    a0 = acc_q.size();
    bytes5 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int i = 0; i < 5; i++) drive(1'b1, bytes5[i]);
    drive(1'b1, 8'hBC);
    check_val("full_ready", tx_ready, 0);
    check_val("full_accepted", acc_q.size() - a0, 5);
    drive(1'b0, 8'h00);
    drain(1500);
    check_val("full_sent", done_q.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      fr = done_q[base + i];
      check_val("full_order", fr[8:1], bytes5[i]);
    end

    // Reset in the middle of 0x55.
    base = done_q.size();
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    k = 0;
    while (!in_frame && k < 50) begin drive(1'b0, 8'h00); k++; end
    check_val("abort_started", in_frame, 1);
    k = 0;
    while (cyc < fs + 37 && k < 100) begin drive(1'b0, 8'h00); k++; end
    check_val("pre_abort_clk", ps2_clk, 0);
    check_val("pre_abort_data", ps2_data, 0);
    resetn = 1'b0;
    #1;
    check_val("abort_clk", ps2_clk, 1);
    check_val("abort_data", ps2_data, 1);
    check_val("abort_busy", busy, 0);
    repeat (4) drive(1'b0, 8'h00);
    resetn = 1'b1;
    repeat (20) drive(1'b0, 8'($urandom));
    check_val("abort_no_frame", done_q.size(), base);
    drive(1'b1, 8'h1C);
    drive(1'b0, 8'h00);
    drain(400);
    check_val("post_abort_count", done_q.size(), base + 1);
    fr = done_q[base];
    check_val("post_abort_bits", fr, 11'b10000111000);

    // Randomized traffic: dense bursts, then sparse pushes.
    base = done_q.size();
    a0 = acc_q.size();
    for (int i = 0; i < 400; i++) drive($urandom_range(0, 99) < 20, 8'($urandom));
    drive(1'b0, 8'h00);
    drain(3000);
    for (int i = 0; i < 1500; i++) drive($urandom_range(0, 99) < 1, 8'($urandom));
    drive(1'b0, 8'h00);
    drain(3000);
    check_val("rand_count", done_q.size() - base, acc_q.size() - a0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
